// File: rtl/sample_capture_ram.sv
// sample_capture_ram: captures the filter output stream into a 512-deep RAM
// after a start pulse, with an optional leading discard of SKIP samples.
// Ports: clock, reset (async, active-high), start, din/din_valid (sample in),
//   rd_addr/rd_data (registered readback), busy, done, wr_count.
// Optional feature macro CAPTURE_CHECKSUM_EN adds output checksum[15:0],
//   the running 16-bit sum of samples written in the current capture.
module sample_capture_ram #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned SKIP   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [7:0] SKIP_LAST =
    8'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]        skip_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              arm;
  logic              we;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = (SKIP > 0) ? S_SKIP : S_CAPTURE;
        end
      end
      S_SKIP: begin
        // the sample that reaches SKIP_LAST is the last one discarded
        if (din_valid && skip_cnt == SKIP_LAST) begin
          state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // writing the top address fills the RAM
        if (din_valid && wr_addr == '1) begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SKIP) || (state == S_CAPTURE);
    done = (state == S_DONE);
    arm  = start && ((state == S_IDLE) || (state == S_DONE));
    we   = din_valid && (state == S_CAPTURE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skip_cnt <= '0;
      wr_addr  <= '0;
      wr_count <= '0;
`ifdef CAPTURE_CHECKSUM_EN
      checksum <= '0;
`endif
    end else if (arm) begin
      skip_cnt <= '0;
      wr_addr  <= '0;
      wr_count <= '0;
`ifdef CAPTURE_CHECKSUM_EN
      checksum <= '0;
`endif
    end else if (state == S_SKIP && din_valid) begin
      skip_cnt <= skip_cnt + 8'd1;
    end else if (we) begin
      wr_addr  <= wr_addr + ADDR_W'(1);
      wr_count <= wr_count + (ADDR_W+1)'(1);
`ifdef CAPTURE_CHECKSUM_EN
      checksum <= checksum + 16'(din);
`endif
    end
  end

  // storage has no reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= din;
    end
  end

  // read-before-write: a same-address read sees the old word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sample_capture_ram.sv
// tb_sample_capture_ram: scoreboard bench for sample_capture_ram with
// two instances (SKIP=0 and SKIP=3) sharing one stimulus stream.
module tb_sample_capture_ram;

  logic       clock = 1'b1;
  logic       reset;
  logic       start;
  logic [9:0] din;
  logic       din_valid;
  logic [8:0] rd_addr;
  logic [9:0] rd_data0, rd_data3;
  logic       busy0, busy3, done0, done3;
  logic [9:0] wc0, wc3;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] cs0, cs3;
`endif

  int total = 0;
  int bad   = 0;
  int q0[$];
  int q3[$];
  logic rd_req  = 1'b0;
  logic rd_pend = 1'b0;
  int mon_e0, mon_e3;

  always #5 clock = ~clock;

  sample_capture_ram #(.DATA_W(10), .ADDR_W(9), .SKIP(0)) u0 (
    .clock(clock), .reset(reset), .start(start),
    .din(din), .din_valid(din_valid),
    .rd_addr(rd_addr), .rd_data(rd_data0),
    .busy(busy0), .done(done0), .wr_count(wc0)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(cs0)
`endif
  );

  sample_capture_ram #(.DATA_W(10), .ADDR_W(9), .SKIP(3)) u3 (
    .clock(clock), .reset(reset), .start(start),
    .din(din), .din_valid(din_valid),
    .rd_addr(rd_addr), .rd_data(rd_data3),
    .busy(busy3), .done(done3), .wr_count(wc3)
`ifdef CAPTURE_CHECKSUM_EN
    , .checksum(cs3)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk_st(input string tag,
                        input int b0, input int d0, input int w0,
                        input int b3, input int d3, input int w3);
    chk({tag, "_busy0"}, int'(busy0), b0);
    chk({tag, "_done0"}, int'(done0), d0);
    chk({tag, "_wc0"},   int'(wc0),   w0);
    chk({tag, "_busy3"}, int'(busy3), b3);
    chk({tag, "_done3"}, int'(done3), d3);
    chk({tag, "_wc3"},   int'(wc3),   w3);
  endtask

  task automatic rd(input int a, input int e0, input int e3);
    rd_addr = 9'(a);
    rd_req  = 1'b1;
    q0.push_back(e0);
    q3.push_back(e3);
    cyc();
    rd_req = 1'b0;
  endtask

  // monitor: a read issued before an edge is compared after it
  always @(posedge clock) rd_pend <= rd_req;

  always @(negedge clock) begin
    if (rd_pend) begin
      if (q0.size() == 0 || q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_queue: got empty required entry");
      end else begin
        mon_e0 = q0.pop_front();
        mon_e3 = q3.pop_front();
        chk("rd_data0", int'(rd_data0), mon_e0);
        chk("rd_data3", int'(rd_data3), mon_e3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int bc0, bc3, k, c, acc, e0, e3;
    bit pulsed;
    reset = 1'b1;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    rd_addr = '0;

    // reset and idle
    #3;
    chk_st("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_rd0", int'(rd_data0), 0);
    chk("reset_rd3", int'(rd_data3), 0);
`ifdef CAPTURE_CHECKSUM_EN
    chk("reset_cs0", int'(cs0), 0);
`endif
    #2 reset = 1'b0;
    #1;
    repeat (3) begin
      cyc();
      chk_st("idle", 0, 0, 0, 0, 0, 0);
    end

    // full ramp capture; start-edge sample must not be stored
    start = 1'b1;
    din = 10'd999;
    din_valid = 1'b1;
    cyc();
    start = 1'b0;
    bc0 = 0;
    bc3 = 0;
    for (int i = 0; i < 515; i++) begin
      if (busy0) bc0++;
      if (busy3) bc3++;
      if (i == 512) chk_st("cap512", 0, 1, 512, 1, 0, 509);
      din = 10'(i);
      din_valid = 1'b1;
      cyc();
    end
    din_valid = 1'b0;
    chk_st("cap_done", 0, 1, 512, 0, 1, 512);
    chk("busy_cycles0", bc0, 512);
    chk("busy_cycles3", bc3, 515);
`ifdef CAPTURE_CHECKSUM_EN
    chk("cs0_ramp", int'(cs0), 65280);
    chk("cs3_ramp", int'(cs3), 1280);
`endif
    rd(0, 0, 3);
    rd(255, 255, 258);
    rd(511, 511, 514);

    // restart from DONE, gapped stream, ignored mid-capture start
    start = 1'b1;
    din = 10'd999;
    din_valid = 1'b1;
    cyc();
    start = 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
    chk("cs0_clear", int'(cs0), 0);
    chk("cs3_clear", int'(cs3), 0);
`endif
    k = 0;
    c = 0;
    pulsed = 1'b0;
    while (!done3 && c < 2000) begin
      acc = c - c / 4;
      e0 = (acc > 512) ? 512 : acc;
      e3 = (acc < 3) ? 0 : ((acc - 3 > 512) ? 512 : acc - 3);
      chk("gap_wc0", int'(wc0), e0);
      chk("gap_wc3", int'(wc3), e3);
      start = !pulsed && int'(wc0) == 10;
      if (start) pulsed = 1'b1;
      din_valid = (c % 4) != 3;
      din = 10'(100 + k);
      if (din_valid) k++;
      // addr 0 written at this edge: old word first, new word next cycle
      if (c <= 1) begin
        rd_addr = '0;
        rd_req = 1'b1;
        q0.push_back((c == 0) ? 0 : 100);
        q3.push_back(3);
      end else begin
        rd_req = 1'b0;
      end
      c++;
      cyc();
    end
    start = 1'b0;
    din_valid = 1'b0;
    rd_req = 1'b0;
    chk("gap_bound", int'(done3), 1);
    chk("gap_pulsed", int'(pulsed), 1);
    chk_st("gap_done", 0, 1, 512, 0, 1, 512);
    rd(0, 100, 103);
    rd(200, 300, 303);
    rd(511, 611, 614);

    // reset in the middle of a capture
    start = 1'b1;
    din = 10'd999;
    din_valid = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      din = 10'(512 + i);
      din_valid = 1'b1;
      cyc();
    end
    chk("mid_wc0", int'(wc0), 200);
    chk("mid_wc3", int'(wc3), 197);
    reset = 1'b1;
    din_valid = 1'b0;
    #2;
    chk_st("rst_mid", 0, 0, 0, 0, 0, 0);
`ifdef CAPTURE_CHECKSUM_EN
    chk("rst_cs0", int'(cs0), 0);
`endif
    reset = 1'b0;
    cyc();
    chk_st("post_rst", 0, 0, 0, 0, 0, 0);
    rd(0, 512, 515);
    rd(197, 709, 300);
    rd(199, 711, 302);
    rd(200, 300, 303);

    cyc();
    cyc();
    chk("queue_empty", q0.size() + q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
